nios_pio_edge_irq: RTL and testbench

- Parametrised Avalon-MM general-purpose I/O port for the Nios II system; successor to the fixed 8-bit output-only LED port.
- Adds configurable width, a per-bit direction register and atomic set/clear writes to the output register.
- Adds synchronised input sampling with per-bit edge capture and a maskable level interrupt to the CPU.
- Sits on the system interconnect as a zero-wait-state slave; drives board pins through `out_port`/`oe` and reads them on `in_port`.

---
 rtl/nios_pio_pkg.sv | 16 +
 rtl/nios_pio_sync.sv | 29 ++
 rtl/nios_pio_edge_irq.sv | 120 ++++++++++++
 tb/tb_nios_pio_edge_irq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios II parallel I/O port: register word offsets
// and the edge-capture mode encodings.
package nios_pio_pkg;

  localparam logic [2:0] PIO_DATA    = 3'd0;
  localparam logic [2:0] PIO_DIR     = 3'd1;
  localparam logic [2:0] PIO_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_sync.sv
// Multi-stage flop chain bringing the asynchronous pin inputs into the clk domain.
module nios_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/nios_pio_edge_irq.sv
// Avalon-MM GPIO slave: output/direction registers with atomic set/clear,
// synchronised inputs, per-bit edge capture and a maskable level interrupt.
module nios_pio_edge_irq
  import nios_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter logic [31:0] DIR_RESET   = 32'hFFFF_FFFF,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_oe;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_in_prev;
  logic [WIDTH-1:0] r_edge_hit;
  logic [2:0]       r_arm_cnt;

  logic [WIDTH-1:0] w_in_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_cap_clr;
  logic [WIDTH-1:0] w_cap_next;
  logic             w_wr;
  logic             w_armed;
  logic             w_unused_wdata;

  nios_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (in_port),
    .o_sync  (w_in_sync)
  );

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_armed        = (r_arm_cnt == ARM_CYCLES);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == EDGE_RISE) begin : g_rise
        assign w_edge[gi] = w_in_sync[gi] & ~r_in_prev[gi];
      end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign w_edge[gi] = ~w_in_sync[gi] & r_in_prev[gi];
      end else begin : g_any
        assign w_edge[gi] = w_in_sync[gi] ^ r_in_prev[gi];
      end
    end
  endgenerate

  // A new edge outranks a simultaneous software clear so no event is dropped.
  assign w_cap_clr  = (w_wr && (address == PIO_EDGECAP)) ? w_wdata : '0;
  assign w_cap_next = (r_cap & ~w_cap_clr) | (r_edge_hit & ~r_oe);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out      <= RESET_VALUE[WIDTH-1:0];
      r_oe       <= DIR_RESET[WIDTH-1:0];
      r_mask     <= '0;
      r_cap      <= '0;
      r_in_prev  <= '0;
      r_edge_hit <= '0;
      r_arm_cnt  <= '0;
    end else begin
      r_in_prev  <= w_in_sync;
      r_edge_hit <= w_armed ? w_edge : '0;
      r_cap      <= w_cap_next;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + 3'd1;
      end
      if (w_wr) begin
        case (address)
          PIO_DATA:    r_out  <= w_wdata;
          PIO_DIR:     r_oe   <= w_wdata;
          PIO_IRQMASK: r_mask <= w_wdata;
          PIO_OUTSET:  r_out  <= r_out | w_wdata;
          PIO_OUTCLR:  r_out  <= r_out & ~w_wdata;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_DATA:    readdata[WIDTH-1:0] = (r_oe & r_out) | (~r_oe & w_in_sync);
      PIO_DIR:     readdata[WIDTH-1:0] = r_oe;
      PIO_IRQMASK: readdata[WIDTH-1:0] = r_mask;
      PIO_EDGECAP: readdata[WIDTH-1:0] = r_cap;
      default:     readdata = '0;
    endcase
  end

  assign out_port = r_out;
  assign oe       = r_oe;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_nios_pio_edge_irq.sv
// Scoreboard bench for nios_pio_edge_irq: stimulus pushes expected outputs
// computed from a pin-history model, a negedge monitor pops and compares.
module tb_nios_pio_edge_irq;
  import nios_pio_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int ET = EDGE_RISE;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic [W-1:0]  out_port;
  logic [W-1:0]  oe;
  logic          irq;

  always #5 clk = ~clk;

  nios_pio_edge_irq #(
    .WIDTH       (W),
    .RESET_VALUE (32'h0),
    .DIR_RESET   (32'hFFFF_FFFF),
    .EDGE_TYPE   (ET),
    .SYNC_STAGES (S)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  typedef struct {
    int           id;
    bit           is_read;
    logic [2:0]   addr;
    logic [31:0]  rdata;
    logic [W-1:0] outp;
    logic [W-1:0] oev;
    logic         irqv;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   item_id = 0;

  // Reference model: register contents plus the history of pin values
  // sampled at each clock edge since reset release (hist[1] is the first).
  logic [W-1:0] m_out, m_oe, m_mask, m_cap;
  logic [W-1:0] hist [0:4095];
  int           m_e;
  logic [W-1:0] pin_v = '0;

  function automatic logic [W-1:0] edge_of(input logic [W-1:0] cur, input logic [W-1:0] prev);
    case (ET)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

  function automatic logic [W-1:0] pin_at(input int k);
    if (k < 1) return '0;
    return hist[k];
  endfunction

  task automatic model_reset();
    m_out  = '0;
    m_oe   = '1;
    m_mask = '0;
    m_cap  = '0;
    m_e    = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    logic [W-1:0] sync_v;
    logic [31:0]  r;
    sync_v = pin_at(m_e - S + 1);
    r = '0;
    case (a)
      3'd0: r[W-1:0] = (m_oe & m_out) | (~m_oe & sync_v);
      3'd1: r[W-1:0] = m_oe;
      3'd2: r[W-1:0] = m_mask;
      3'd3: r[W-1:0] = m_cap;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock edge: a pin change sampled at edge k lands in EDGECAP at edge
  // k+S+1; the transition out of the reset state (k=1) is never an event.
  task automatic model_edge(input bit cs, input bit wn, input logic [2:0] a,
                            input logic [31:0] wd, input logic [W-1:0] pin);
    logic [W-1:0] set_v, clr_v, d;
    int k;
    if (m_e < 4095) m_e++;
    hist[m_e] = pin;
    set_v = '0;
    clr_v = '0;
    d = wd[W-1:0];
    k = m_e - S - 1;
    if (k >= 2) set_v = edge_of(hist[k], hist[k-1]) & ~m_oe;
    if (cs && !wn) begin
      case (a)
        3'd0: m_out  = d;
        3'd1: m_oe   = d;
        3'd2: m_mask = d;
        3'd3: clr_v  = d;
        3'd4: m_out  = m_out | d;
        3'd5: m_out  = m_out & ~d;
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr_v) | set_v;
  endtask

  // Called at posedge+1: drive one cycle, queue its expectation, advance.
  task automatic step(input bit rn, input bit cs, input bit wn, input logic [2:0] a,
                      input logic [31:0] wd);
    exp_t it;
    reset_n    = rn;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = pin_v;
    if (!rn) model_reset();
    it.id      = item_id++;
    it.is_read = rn && cs && wn;
    it.addr    = a;
    it.rdata   = exp_read(a);
    it.outp    = m_out;
    it.oev     = m_oe;
    it.irqv    = |(m_cap & m_mask);
    sb_q.push_back(it);
    @(posedge clk);
    if (rn) model_edge(cs, wn, a, wd, pin_v);
    else    model_reset();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b1, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s item %0d: got %h expected %h", name, id, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t it;
      it = sb_q.pop_front();
      if (it.is_read) chk($sformatf("readdata@%0d", it.addr), it.id, readdata, it.rdata);
      chk("out_port", it.id, 32'(out_port), 32'(it.outp));
      chk("oe",       it.id, 32'(oe),       32'(it.oev));
      chk("irq",      it.id, 32'(irq),      32'(it.irqv));
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    // Reset state and read map with default parameters
    pin_v = '0;
    rst_cycles(3);
    idle(1);
    for (int a = 0; a < 8; a++) rd(3'(a));
    for (int a = 0; a < 8; a++) wr(3'(a), 32'h0000_0000);
    wr(3'd1, 32'hFF);
    for (int a = 6; a < 8; a++) wr(3'(a), 32'hFFFF_FFFF);
    // DATA / OUTSET / OUTCLR
    wr(3'd0, 32'hA5);
    wr(3'd4, 32'h0A);
    wr(3'd5, 32'h81);
    rd(3'd0);
    for (int a = 4; a < 8; a++) rd(3'(a));
    // Mixed direction readback
    wr(3'd1, 32'h0F);
    wr(3'd0, 32'h03);
    pin_v = 8'hC0;
    rd(3'd0); rd(3'd0); rd(3'd0); rd(3'd0);
    // Single rising edge on bit 0, irq latency and clear
    wr(3'd1, 32'h00);
    pin_v = 8'h00;
    idle(4);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    pin_v = 8'h01;
    idle(1);
    rd(3'd3); rd(3'd3); rd(3'd3);
    wr(3'd3, 32'h01);
    rd(3'd3);
    // Clear coinciding with a new capture on the same bit: set wins
    pin_v = 8'h01; idle(1);
    wr(3'd3, 32'h00);
    pin_v = 8'h00; idle(4);
    pin_v = 8'h01; idle(S + 1);
    wr(3'd3, 32'hFF);
    pin_v = 8'h00; idle(S + 1);
    pin_v = 8'h01; idle(S);
    wr(3'd3, 32'h01);
    rd(3'd3);
    idle(2);
    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      if ($urandom_range(0, 2) == 0) pin_v = W'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4)      rd(3'($urandom_range(0, 7)));
      else if (r < 8) wr(3'($urandom_range(0, 7)), $urandom);
      else if (r < 9) wr(3'd1, 32'($urandom_range(0, 3) == 0 ? $urandom : 32'h0));
      else            idle(1);
    end
    // Reset mid-run with pins held high, then arming window
    pin_v = 8'hFF;
    wr(3'd2, 32'hFF);
    rst_cycles(3);
    wr(3'd1, 32'h00);
    wr(3'd2, 32'hFF);
    for (int i = 0; i < 20; i++) rd(3'd3);
    rd(3'd0);
    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
